// File: rtl/pararam_pkg.sv
// Shared sizing defaults for the ParaRAM round-robin arbiter.
// Latency: none (constants only). Backpressure: not applicable.
// Pointer width is derived from the requester count.
package pararam_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF = 24;
    localparam int MAX_BURST_DEF  = 4;
    localparam int PTR_W          = $clog2(NUM_REQ_DEF);

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pararam_rr_pick.sv
// Round-robin pick: first asserted req at or after ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; a requester that loses simply holds its req.
module pararam_rr_pick
    import pararam_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = ptr_width(NUM_REQ_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic          win_vld,
    output logic [PW-1:0] win_idx
);

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        // Scan farthest-first so the nearest asserted requester wins last.
        for (int k = N - 1; k >= 0; k--) begin
            automatic int c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (req[c]) begin
                win_vld = 1'b1;
                win_idx = PW'(c);
            end
        end
        win_oh = win_vld ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/pararam_arbiter.sv
// Round-robin sharing of the single-port ParaRAM; PARARAM_BURST_EN enables burst regrants.
// Latency: grant/RAM drive same cycle as req; read data strobed one cycle after grant.
// Backpressure: losers hold req/we/addr/wdata until gnt; no bubbles between grants.
module pararam_arbiter
    import pararam_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          mem_en,
    output logic                          mem_wc,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int PW = ptr_width(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_vld;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_vld;
    logic [PW-1:0]      win_idx;
    logic               grant;

    pararam_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .win_oh  (pick_oh),
        .win_vld (pick_vld),
        .win_idx (pick_idx)
    );

`ifdef PARARAM_BURST_EN
    localparam int BW = $clog2(MAX_BURST) + 1;

    logic [PW-1:0] owner;
    logic          owner_act;
    logic [BW-1:0] burst_cnt;
    logic          burst_rep;

    // Last cycle's winner keeps the RAM while it still asks and has budget left.
    assign burst_rep = owner_act && req[owner] && (burst_cnt < BW'(MAX_BURST - 1));
    assign win_vld   = burst_rep || pick_vld;
    assign win_idx   = burst_rep ? owner : pick_idx;
    assign win_oh    = burst_rep ? (NUM_REQ'(1) << owner) : pick_oh;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= '0;
            owner_act <= 1'b0;
            burst_cnt <= '0;
        end else begin
            owner     <= grant ? win_idx : owner;
            owner_act <= grant;
            burst_cnt <= (grant && burst_rep) ? burst_cnt + BW'(1) : '0;
        end
    end
`else
    assign win_vld = pick_vld;
    assign win_idx = pick_idx;
    assign win_oh  = pick_oh;
`endif

    assign grant     = win_vld && !rst;
    assign gnt       = grant ? win_oh : '0;
    assign mem_en    = grant;
    assign mem_wc    = grant && we[win_idx];
    assign mem_addr  = grant ? addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mem_wdata = grant ? wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // A read in flight when reset arrives must not be reported to its owner.
    assign rvalid = rvalid_q & {NUM_REQ{~rst}};
    assign rdata  = mem_rdata;

    // Repeat grants in a burst rewrite the same winner+1, so the pointer
    // effectively moves past the owner only once its burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt & ~we;
            if (grant)
                rr_ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

endmodule

// File: tb/tb_pararam_arbiter.sv
// Directed table plus hand sequences for pararam_arbiter with a behavioural RAM.
// Latency: checks sampled 1 time unit after each falling edge. Backpressure: n/a.
// Burst expectations are selected when PARARAM_BURST_EN is defined.
module tb_pararam_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_wc;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pararam_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_wc    (mem_wc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Registered-read single-port RAM model.
    always @(posedge clk) begin
        if (mem_en && mem_wc) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_wc) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] we;
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rvalid;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] w,
                       input logic [N-1:0] eg, input logic [N-1:0] ev);
        vec_t v;
        v.rst = r; v.req = rq; v.we = w; v.exp_gnt = eg; v.exp_rvalid = ev;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] req_addr(input int i);
        return AW'(i * 9 + 3);
    endfunction

    function automatic logic [DW-1:0] req_wdata(input int i);
        return DW'(24'hA00000 + i * 24'h010101);
    endfunction

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return DW'(24'h100000) + DW'(a);
    endfunction

    initial begin
        logic [AW-1:0] exp_addr, prev_addr;
        logic [DW-1:0] exp_wd;
        logic          exp_wc;

        for (int a = 0; a < (1 << AW); a++) ram[a] = init_word(AW'(a));
        mem_rdata = '0;
        rst = 1'b1; req = '0; we = '0;
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = req_addr(i);
            wdata[i*DW +: DW] = req_wdata(i);
        end

        //   rst  req      we       gnt      rvalid
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
`ifdef PARARAM_BURST_EN
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0000);
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0010);
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0010);
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b0010);
        add(0, 4'b1010, 4'b0000, 4'b1000, 4'b0010);
        add(0, 4'b1010, 4'b0000, 4'b1000, 4'b1000);
        add(0, 4'b1010, 4'b0000, 4'b1000, 4'b1000);
        add(0, 4'b1010, 4'b0000, 4'b1000, 4'b1000);
        add(0, 4'b1010, 4'b0000, 4'b0010, 4'b1000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
`else
        add(0, 4'b1111, 4'b0000, 4'b0001, 4'b0000);
        add(0, 4'b1111, 4'b0000, 4'b0010, 4'b0001);
        add(0, 4'b1111, 4'b0000, 4'b0100, 4'b0010);
        add(0, 4'b1111, 4'b0000, 4'b1000, 4'b0100);
        add(0, 4'b1111, 4'b0000, 4'b0001, 4'b1000);
        add(0, 4'b1111, 4'b0000, 4'b0010, 4'b0001);
        add(0, 4'b1111, 4'b0000, 4'b0100, 4'b0010);
        add(0, 4'b1111, 4'b0000, 4'b1000, 4'b0100);
        add(0, 4'b0100, 4'b0000, 4'b0100, 4'b1000);
        add(0, 4'b0101, 4'b0000, 4'b0001, 4'b0100);
        add(0, 4'b0101, 4'b0000, 4'b0100, 4'b0001);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(0, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
`endif

        prev_addr = '0;
        foreach (tbl[k]) begin
            @(negedge clk);
            rst = tbl[k].rst; req = tbl[k].req; we = tbl[k].we;
            #1;
            exp_addr = '0; exp_wd = '0; exp_wc = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (tbl[k].exp_gnt[i]) begin
                    exp_addr = req_addr(i);
                    exp_wd   = req_wdata(i);
                    exp_wc   = tbl[k].we[i];
                end
            end
            check($sformatf("tbl%0d gnt", k), 32'(gnt), 32'(tbl[k].exp_gnt));
            check($sformatf("tbl%0d mem_en", k), 32'(mem_en), 32'(tbl[k].exp_gnt != '0));
            check($sformatf("tbl%0d mem_wc", k), 32'(mem_wc), 32'(exp_wc));
            check($sformatf("tbl%0d mem_addr", k), 32'(mem_addr), 32'(exp_addr));
            check($sformatf("tbl%0d mem_wdata", k), 32'(mem_wdata), 32'(exp_wd));
            check($sformatf("tbl%0d rvalid", k), 32'(rvalid), 32'(tbl[k].exp_rvalid));
            if (tbl[k].exp_rvalid != '0)
                check($sformatf("tbl%0d rdata", k), 32'(rdata), 32'(init_word(prev_addr)));
            prev_addr = exp_addr;
        end

        // Write by requester 1 followed immediately by a read of the same word by requester 2.
        @(negedge clk);
        addr[1*AW +: AW] = 6'h05; wdata[1*DW +: DW] = 24'hABCDEF; addr[2*AW +: AW] = 6'h05;
        req = 4'b0010; we = 4'b0010;
        #1;
        check("wr gnt", 32'(gnt), 32'(4'b0010));
        check("wr mem_wc", 32'(mem_wc), 32'd1);
        check("wr mem_addr", 32'(mem_addr), 32'h05);
        check("wr mem_wdata", 32'(mem_wdata), 32'hABCDEF);
        @(negedge clk);
        req = 4'b0100; we = 4'b0000;
        #1;
        check("rd gnt", 32'(gnt), 32'(4'b0100));
        check("rd mem_wc", 32'(mem_wc), 32'd0);
        check("rd no rvalid after write", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("rd rvalid", 32'(rvalid), 32'(4'b0100));
        check("rd rdata", 32'(rdata), 32'hABCDEF);
        check("idle mem_en", 32'(mem_en), 32'd0);

        // Read granted, then reset lands the next cycle: strobe suppressed, pointer back to 0.
        @(negedge clk);
        req = 4'b0100;
        #1;
        check("rstrd gnt", 32'(gnt), 32'(4'b0100));
        @(negedge clk);
        rst = 1'b1; req = 4'b1111;
        #1;
        check("rstrd rvalid", 32'(rvalid), 32'd0);
        check("rstrd gnt forced", 32'(gnt), 32'd0);
        check("rstrd mem_en forced", 32'(mem_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst gnt", 32'(gnt), 32'(4'b0001));
        check("post-rst rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("post-rst rvalid next", 32'(rvalid), 32'(4'b0001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
